// File: rtl/sdram_refresh_sched.sv
`default_nettype none
// ============================================================================
// Module      : sdram_refresh_sched
// Description : SDRAM power-up initialisation and periodic auto-refresh
//               scheduler.
//               Power-up sequence:
//                 INIT_WAIT NOPs, PRECHARGE ALL, AUTO REFRESH x2, LOAD MODE.
//               After that a free-running interval timer accrues refresh
//               debt (owed). While debt is outstanding the block requests
//               the bus. Each grant runs one PRECHARGE ALL + AUTO REFRESH.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               ref_gnt   - bus grant, honoured only in IDLE with debt
//               cmd       - {cs_n,ras_n,cas_n,we_n}
//               a, ba     - SDRAM address / bank (ba is always 0)
//               ref_req   - refresh owed, requesting the bus
//               busy      - block currently owns the SDRAM bus
//               init_done - sticky, init sequence complete
//               urgent    - owed count at MAX_OWED (one-cycle lag)
//               overflow  - sticky, a tick arrived with debt saturated
//               ref_count - AUTO REFRESH counter (SDRAM_REFRESH_STATS_EN only)
// Options     : define SDRAM_REFRESH_STATS_EN to add the ref_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_refresh_sched #(
    parameter int          INIT_WAIT    = 20000,
    parameter int          REF_INTERVAL = 390,
    parameter int          TRP          = 2,
    parameter int          TRFC         = 7,
    parameter int          TMRD         = 2,
    parameter logic [12:0] MODE_REG     = 13'h0032,
    parameter int          MAX_OWED     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ref_gnt,
    output logic [3:0]  cmd,
    output logic [12:0] a,
    output logic [1:0]  ba,
    output logic        ref_req,
    output logic        busy,
    output logic        init_done,
    output logic        urgent,
    output logic        overflow
`ifdef SDRAM_REFRESH_STATS_EN
    ,
    output logic [15:0] ref_count
`endif
);

    // Command encodings {cs_n,ras_n,cas_n,we_n}
    localparam logic [3:0] c_DESEL = 4'b1111;
    localparam logic [3:0] c_NOP   = 4'b0111;
    localparam logic [3:0] c_PRE   = 4'b0010;
    localparam logic [3:0] c_REF   = 4'b0001;
    localparam logic [3:0] c_LMR   = 4'b0000;

    // States: command states last exactly one cycle, the following wait
    // state covers the remaining (spacing - 1) cycles.
    localparam logic [3:0] S_INIT_WAIT = 4'd0;
    localparam logic [3:0] S_INIT_PRE  = 4'd1;
    localparam logic [3:0] S_INIT_TRP  = 4'd2;
    localparam logic [3:0] S_INIT_REF1 = 4'd3;
    localparam logic [3:0] S_INIT_RFC1 = 4'd4;
    localparam logic [3:0] S_INIT_REF2 = 4'd5;
    localparam logic [3:0] S_INIT_RFC2 = 4'd6;
    localparam logic [3:0] S_INIT_LMR  = 4'd7;
    localparam logic [3:0] S_INIT_MRD  = 4'd8;
    localparam logic [3:0] S_IDLE      = 4'd9;
    localparam logic [3:0] S_PRE       = 4'd10;
    localparam logic [3:0] S_TRP       = 4'd11;
    localparam logic [3:0] S_REF       = 4'd12;
    localparam logic [3:0] S_RFC       = 4'd13;

    localparam int c_MAX_A = (INIT_WAIT > TRFC) ? INIT_WAIT : TRFC;
    localparam int c_MAX_B = (TRP > TMRD) ? TRP : TMRD;
    localparam int c_MAX_T = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W = $clog2(c_MAX_T + 1);
    localparam int c_TMR_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    localparam logic [c_CNT_W-1:0] c_INIT_LAST = c_CNT_W'(INIT_WAIT);
    localparam logic [c_CNT_W-1:0] c_TRP_LAST  = c_CNT_W'(TRP - 1);
    localparam logic [c_CNT_W-1:0] c_TRFC_LAST = c_CNT_W'(TRFC - 1);
    localparam logic [c_CNT_W-1:0] c_TMRD_LAST = c_CNT_W'(TMRD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(REF_INTERVAL - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [3:0]         c_MAX_OWED  = 4'(MAX_OWED);

    logic [3:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_TMR_W-1:0] r_tmr;
    logic [3:0]         r_owed;

    logic [3:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         w_cmd_nxt;
    logic [12:0]        w_a_nxt;
    logic [3:0]         w_owed_nxt;
    logic               w_tick;
    logic               w_dec;

    // Next-state logic. Outputs are registered from the next state so a
    // command appears on the bus in the same cycle its state is entered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_ONE;
        w_cmd_nxt   = c_NOP;
        w_a_nxt     = '0;
        case (r_state)
            S_INIT_WAIT: if (r_cnt == c_INIT_LAST) w_state_nxt = S_INIT_PRE;
            S_INIT_PRE:  w_state_nxt = (TRP == 1) ? S_INIT_REF1 : S_INIT_TRP;
            S_INIT_TRP:  if (r_cnt == c_TRP_LAST) w_state_nxt = S_INIT_REF1;
            S_INIT_REF1: w_state_nxt = (TRFC == 1) ? S_INIT_REF2 : S_INIT_RFC1;
            S_INIT_RFC1: if (r_cnt == c_TRFC_LAST) w_state_nxt = S_INIT_REF2;
            S_INIT_REF2: w_state_nxt = (TRFC == 1) ? S_INIT_LMR : S_INIT_RFC2;
            S_INIT_RFC2: if (r_cnt == c_TRFC_LAST) w_state_nxt = S_INIT_LMR;
            S_INIT_LMR:  w_state_nxt = (TMRD == 1) ? S_IDLE : S_INIT_MRD;
            S_INIT_MRD:  if (r_cnt == c_TMRD_LAST) w_state_nxt = S_IDLE;
            S_IDLE: begin
                w_cnt_nxt = r_cnt;
                if (ref_req && ref_gnt) w_state_nxt = S_PRE;
            end
            S_PRE:       w_state_nxt = (TRP == 1) ? S_REF : S_TRP;
            S_TRP:       if (r_cnt == c_TRP_LAST) w_state_nxt = S_REF;
            S_REF:       w_state_nxt = (TRFC == 1) ? S_IDLE : S_RFC;
            S_RFC:       if (r_cnt == c_TRFC_LAST) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_INIT_WAIT;
        endcase

        // Wait states count from 1 so that exit at (spacing - 1) places
        // the next command exactly 'spacing' cycles after the previous one.
        if (w_state_nxt != r_state) w_cnt_nxt = c_CNT_ONE;

        case (w_state_nxt)
            S_INIT_PRE, S_PRE: begin
                w_cmd_nxt = c_PRE;
                w_a_nxt   = 13'h0400;
            end
            S_INIT_REF1, S_INIT_REF2, S_REF: w_cmd_nxt = c_REF;
            S_INIT_LMR: begin
                w_cmd_nxt = c_LMR;
                w_a_nxt   = MODE_REG;
            end
            default: w_cmd_nxt = c_NOP;
        endcase
    end

    // Debt accounting: tick and refresh in the same cycle cancel out.
    assign w_tick = init_done && (r_tmr == c_TMR_LAST);
    assign w_dec  = (w_state_nxt == S_REF);

    always_comb begin
        w_owed_nxt = r_owed;
        case ({w_tick, w_dec})
            2'b10:   if (r_owed != c_MAX_OWED) w_owed_nxt = r_owed + 4'd1;
            2'b01:   w_owed_nxt = r_owed - 4'd1;
            default: w_owed_nxt = r_owed;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_INIT_WAIT;
            r_cnt     <= '0;
            r_tmr     <= '0;
            r_owed    <= '0;
            cmd       <= c_DESEL;
            a         <= '0;
            ba        <= '0;
            ref_req   <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            urgent    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_owed    <= w_owed_nxt;
            cmd       <= w_cmd_nxt;
            a         <= w_a_nxt;
            ba        <= 2'b00;
            busy      <= (w_state_nxt != S_IDLE);
            init_done <= init_done | (w_state_nxt == S_IDLE);
            ref_req   <= (w_state_nxt == S_IDLE) && (w_owed_nxt != 4'd0);
            urgent    <= (r_owed == c_MAX_OWED);
            overflow  <= overflow | (w_tick && (r_owed == c_MAX_OWED));
            // Timer is held at zero until init completes, so the first tick
            // lands REF_INTERVAL cycles after init_done rises.
            if (!init_done || w_tick) r_tmr <= '0;
            else                      r_tmr <= r_tmr + c_TMR_ONE;
        end
    end

`ifdef SDRAM_REFRESH_STATS_EN
    logic w_any_ref;
    assign w_any_ref = (w_state_nxt == S_INIT_REF1) || (w_state_nxt == S_INIT_REF2) ||
                       (w_state_nxt == S_REF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ref_count <= '0;
        else if (w_any_ref) ref_count <= ref_count + 16'd1;
    end
`endif

endmodule
`default_nettype wire
